// File: rtl/led_sequencer_pkg.sv
// Shared types for the LED sequencer: display modes and controller states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package led_sequencer_pkg;

  // Pattern shown once the intro has finished; encoding matches the mode pins.
  typedef enum logic [1:0] {
    MODE_HOST   = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  // Controller states; INTRO is the reset state.
  typedef enum logic {
    ST_INTRO = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Width of a counter that must hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_sequencer_tick_divider.sv
// Prescaler producing a one-cycle tick every TICK_CYCLES clocks.
// Latency: tick is decoded from the count register, high while count is TICK_CYCLES-1.
// Backpressure: none; clear restarts the count at 0 on the next edge.
module tick_divider
  import led_sequencer_pkg::*;
#(
  parameter int TICK_CYCLES = 500_000
) (
  input  logic clock,
  input  logic reset_b,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] count;

  // Free-running modulo counter; clear and wrap both return it to 0.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // With TICK_CYCLES=1 the count is pinned at 0 == LAST, so tick is always high.
  assign tick = (count == LAST);

endmodule

// File: rtl/led_sequencer.sv
// LED animation sequencer: intro fill/drain sweeps, then HOST/FILL/BOUNCE/BLINK patterns.
// Latency: leds registered; HOST follows host_leds one cycle later, patterns step per tick.
// Backpressure: none; start restarts the intro at once, reset abandons everything.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_CYCLES  = 500_000,
  parameter int INTRO_PASSES = 1
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] host_leds,
  input  logic             start,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             done
);

  localparam int SW = cnt_width(2 * WIDTH);
  localparam int PW = cnt_width(INTRO_PASSES);
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * WIDTH - 1);
  localparam logic [SW-1:0] FILL_STEPS = SW'(WIDTH);
  localparam logic [PW-1:0] LAST_PASS = PW'(INTRO_PASSES - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  mode_t            mode_in;
  mode_t            mode_q;
  logic [SW-1:0]    step;
  logic [PW-1:0]    pass;
  logic             fresh;
  logic             dir_up;
  logic             tick;
  logic             restart;
  logic             tick_clear;
  logic             step_last;
  logic [WIDTH-1:0] fill_nxt;
  logic [WIDTH-1:0] bounce_nxt;
  logic             dir_nxt;

  assign mode_in = mode_t'(mode);

  // A RUN pattern restarts on the first RUN cycle after an intro and whenever mode changes.
  assign restart    = (state == ST_RUN) && (fresh || (mode_in != mode_q));
  assign tick_clear = start || restart;
  assign busy       = (state == ST_INTRO);
  assign step_last  = (step == LAST_STEP);

  tick_divider #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clock   (clock),
    .reset_b (reset_b),
    .clear   (tick_clear),
    .tick    (tick)
  );

  // Fill/drain step shared by the intro and FILL mode: first WIDTH steps shift a one in.
  always_comb begin
    fill_nxt = leds >> 1;
    if (step < FILL_STEPS) begin
      fill_nxt = (leds >> 1) | MSB;
    end
  end

  // Bounce step: move one place, turning round at either end without repeating it.
  always_comb begin
    bounce_nxt = leds;
    dir_nxt    = dir_up;
    if (WIDTH > 1) begin
      if (dir_up) begin
        if (leds[WIDTH-1]) begin
          bounce_nxt = leds >> 1;
          dir_nxt    = 1'b0;
        end else begin
          bounce_nxt = leds << 1;
        end
      end else begin
        if (leds[0]) begin
          bounce_nxt = leds << 1;
          dir_nxt    = 1'b1;
        end else begin
          bounce_nxt = leds >> 1;
        end
      end
    end
  end

  // Controller: start beats everything, intro advances per tick, RUN restarts then animates.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state  <= ST_INTRO;
      leds   <= '0;
      step   <= '0;
      pass   <= '0;
      done   <= 1'b0;
      mode_q <= MODE_HOST;
      fresh  <= 1'b0;
      dir_up <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= ST_INTRO;
        leds  <= '0;
        step  <= '0;
        pass  <= '0;
      end else if (state == ST_INTRO) begin
        if (tick) begin
          leds <= fill_nxt;
          if (step_last) begin
            step <= '0;
            if (pass == LAST_PASS) begin
              pass  <= '0;
              state <= ST_RUN;
              done  <= 1'b1;
              fresh <= 1'b1;
            end else begin
              pass <= pass + 1'b1;
            end
          end else begin
            step <= step + 1'b1;
          end
        end
      end else if (restart) begin
        mode_q <= mode_in;
        fresh  <= 1'b0;
        step   <= '0;
        dir_up <= 1'b0;
        case (mode_in)
          MODE_HOST:   leds <= host_leds;
          MODE_FILL:   leds <= '0;
          MODE_BOUNCE: leds <= MSB;
          MODE_BLINK:  leds <= '1;
        endcase
      end else begin
        case (mode_q)
          MODE_HOST: leds <= host_leds;
          MODE_FILL: begin
            if (tick) begin
              leds <= fill_nxt;
              step <= step_last ? '0 : step + 1'b1;
            end
          end
          MODE_BOUNCE: begin
            if (tick) begin
              leds   <= bounce_nxt;
              dir_up <= dir_nxt;
            end
          end
          MODE_BLINK: begin
            if (tick) begin
              leds <= (leds == '0) ? '1 : '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter WIDTH, 8, number of LED outputs (>=1).
REQ-002 Parameter TICK_CYCLES, 500_000, clock cycles per animation step (>=1).
REQ-003 Parameter INTRO_PASSES, 1, number of intro sweeps run per trigger (>=1).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clock  in  1  system clock; all state SHALL change on its rising edge.
REQ-006 reset_b  in  1  asynchronous, active-low reset.
REQ-007 mode  in  2  pattern after intro: 0 HOST, 1 FILL, 2 BOUNCE, 3 BLINK.
REQ-008 host_leds  in  WIDTH  LED value shown in HOST mode.
REQ-009 start  in  1  single-cycle request to rerun the intro.
REQ-010 leds  out  WIDTH  registered LED drive; bit WIDTH-1 is the leftmost LED.
REQ-011 busy  out  1  high while the intro runs.
REQ-012 done  out  1  one-cycle pulse when the intro finishes.

Function
REQ-013 The tick counter SHALL count 0..TICK_CYCLES-1 and wrap; tick is asserted in the cycle the count equals TICK_CYCLES-1; with TICK_CYCLES=1, tick is asserted every cycle.
REQ-014 Pattern registers SHALL update only on tick edges, except as stated for HOST mode, restarts and reset.
REQ-015 The state machine SHALL have two states: INTRO and RUN; the block enters INTRO when reset is released.
REQ-016 Each INTRO pass SHALL take 2*WIDTH ticks.
  - Fill phase, ticks 1..WIDTH: leds = (leds>>1) | MSB.
  - Drain phase, ticks WIDTH+1..2*WIDTH: leds = leds>>1.
  - leds SHALL be 0 after the last tick of a pass.
REQ-017 After INTRO_PASSES passes: done SHALL pulse high for exactly one cycle, busy SHALL fall in that same cycle, and the state SHALL become RUN.
REQ-018 In RUN with mode HOST, leds SHALL equal host_leds delayed by one cycle, independent of tick.
REQ-019 FILL mode SHALL loop the INTRO fill/drain sequence indefinitely; done SHALL NOT pulse and busy SHALL stay low.
REQ-020 BOUNCE mode SHALL show one lit LED.
  - The LED SHALL start at the MSB and move one position toward the LSB per tick.
  - Direction SHALL reverse after reaching bit 0 or bit WIDTH-1, so no position is repeated at the ends.
  - With WIDTH=1, the single LED SHALL stay lit.
REQ-021 BLINK mode SHALL toggle leds between all-ones and all-zeros on each tick, starting with all-ones.
REQ-022 On the cycle after mode changes in RUN, the new pattern SHALL restart from its initial value and the tick counter SHALL clear to 0. Initial values: FILL 0, BOUNCE MSB, BLINK all-ones.
REQ-023 When start is high in RUN, the block SHALL re-enter INTRO on the next cycle with leds=0, the pass count at 0, the tick counter at 0 and busy=1.
REQ-024 When start is high during INTRO, the intro SHALL restart from its beginning.
REQ-025 When start and a mode change occur in the same cycle, start SHALL take priority; the new mode SHALL take effect after the intro completes.
REQ-026 The mode input SHALL be ignored during INTRO.

Reset
REQ-027 While reset_b=0, outputs SHALL be: leds=0, busy=1, done=0, state=INTRO, tick counter=0, pass count=0.
REQ-028 When reset_b is asserted mid-intro or mid-pattern, the block SHALL abandon the operation immediately, and after release SHALL run the full intro again.

Structure
REQ-029 Package led_sequencer_pkg SHALL hold the mode enum (HOST, FILL, BOUNCE, BLINK) and the state enum (INTRO, RUN).
REQ-030 Sub-module tick_divider SHALL provide the parametrised prescaler with a synchronous clear input and a one-cycle tick output; the tick counter width SHALL be $clog2(TICK_CYCLES), with a minimum of 1.
REQ-031 All arithmetic SHALL be unsigned, and the pass counter SHALL be sized for INTRO_PASSES.

Verification
REQ-032 Intro: WIDTH=4, TICK_CYCLES=3, INTRO_PASSES=1, mode=HOST, release reset -> leds on successive ticks 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; done pulses with the 8th tick (edge 24 after release); busy then falls.
REQ-033 HOST: after the intro, host_leds=1010 -> leds=1010 one cycle later; host_leds change to 0101 -> leds=0101 the next cycle.
REQ-034 BOUNCE: WIDTH=4, mode=2 in RUN -> leds per tick 1000, 0100, 0010, 0001, 0010, 0100, 1000, 0100; a mode change mid-sequence restarts the new pattern at its initial value.
REQ-035 Start priority: start=1 together with mode 2->3 in RUN -> busy=1 next cycle, leds=0, intro runs fully, then BLINK starts at 1111.
REQ-036 Reset mid-intro: assert reset_b=0 at tick 5 -> leds=0 and busy=1 immediately; after release, the sequence restarts at 1000.
REQ-037 Passes and divider: INTRO_PASSES=2, TICK_CYCLES=1 -> 16 consecutive intro steps, one done pulse at step 16, no done pulse at step 8.
